// File: rtl/mfu_pkg.sv
// Shared definitions for the mFU multiplier and its dot-product sequencer:
// precision mode codes and sequencer state encoding.
package mfu_pkg;

    localparam logic [1:0] MODE_NOOP = 2'b00;
    localparam logic [1:0] MODE_8X8  = 2'b01;
    localparam logic [1:0] MODE_4X4  = 2'b10;
    localparam logic [1:0] MODE_2X2  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_DRAIN = 2'b10,
        ST_DONE  = 2'b11
    } seq_state_t;

endpackage

// File: rtl/mfu.sv
// Multi-precision signed multiplier: one 8x8, two 4x4 or four 2x2 lane products
// packed into a 16-bit word, registered once.
module mfu
    import mfu_pkg::*;
(
    input  logic        clk,
    input  logic        nrst,
    input  logic [1:0]  i_mode,
    input  logic [7:0]  i_a,
    input  logic [7:0]  i_b,
    output logic [15:0] o_p
);

    logic [15:0] w_p;
    logic [15:0] r_p_p2;

    // Operands are sign-extended to the lane product width; the low bits of an
    // unsigned product of sign-extended values equal the signed product.
    always_comb begin
        w_p = '0;
        case (i_mode)
            MODE_8X8: w_p = {{8{i_a[7]}}, i_a} * {{8{i_b[7]}}, i_b};
            MODE_4X4: begin
                for (int k = 0; k < 2; k++) begin
                    w_p[8*k +: 8] = {{4{i_a[4*k+3]}}, i_a[4*k +: 4]} *
                                    {{4{i_b[4*k+3]}}, i_b[4*k +: 4]};
                end
            end
            MODE_2X2: begin
                for (int k = 0; k < 4; k++) begin
                    w_p[4*k +: 4] = {{2{i_a[2*k+1]}}, i_a[2*k +: 2]} *
                                    {{2{i_b[2*k+1]}}, i_b[2*k +: 2]};
                end
            end
            default: w_p = '0;
        endcase
    end

    // stage p1 -> p2: product register
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) r_p_p2 <= '0;
        else       r_p_p2 <= w_p;
    end

    assign o_p = r_p_p2;

endmodule

// File: rtl/mfu_lane_reduce.sv
// Combinational reduction of one mFU product word to a single signed sum,
// each lane sign-extended to ACC_W before adding.
module mfu_lane_reduce
    import mfu_pkg::*;
#(
    parameter int ACC_W = 32
)(
    input  logic [1:0]              i_mode,
    input  logic [15:0]             i_p,
    output logic signed [ACC_W-1:0] o_sum
);

    always_comb begin
        o_sum = '0;
        case (i_mode)
            MODE_8X8: o_sum = ACC_W'($signed(i_p));
            MODE_4X4: o_sum = ACC_W'($signed(i_p[15:8])) + ACC_W'($signed(i_p[7:0]));
            MODE_2X2: begin
                for (int k = 0; k < 4; k++) begin
                    o_sum = o_sum + ACC_W'($signed(i_p[4*k +: 4]));
                end
            end
            default: o_sum = '0;
        endcase
    end

endmodule

// File: rtl/mfu_dot_seq.sv
// Dot-product job sequencer: accepts a job config, streams operand beats
// through the mFU, accumulates lane sums and returns one result per job.
module mfu_dot_seq
    import mfu_pkg::*;
#(
    parameter int ACC_W = 32,
    parameter int LEN_W = 16
)(
    input  logic             clk,
    input  logic             nrst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [1:0]       cfg_mode,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [7:0]       op_a,
    input  logic [7:0]       op_b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [ACC_W-1:0] res_data,
    output logic             res_ovf,
    output logic             busy
);

    seq_state_t              r_state, w_state_nxt;
    logic [1:0]              r_mode;
    logic [LEN_W-1:0]        r_cnt;
    logic [7:0]              r_a_p1, r_b_p1;
    logic                    r_vld_p1, r_vld_p2;
    logic signed [ACC_W-1:0] r_acc;
    logic                    r_ovf;

    logic                    w_cfg_hs, w_op_hs, w_last;
    logic [1:0]              w_mfu_mode;
    logic [15:0]             w_p_p2;
    logic signed [ACC_W-1:0] w_sum_p2;

    function automatic logic add_ovf(input logic signed [ACC_W-1:0] x,
                                     input logic signed [ACC_W-1:0] y);
        logic signed [ACC_W-1:0] s;
        s = x + y;
        return (x[ACC_W-1] == y[ACC_W-1]) && (s[ACC_W-1] != x[ACC_W-1]);
    endfunction

    assign w_cfg_hs   = cfg_valid && (r_state == ST_IDLE);
    assign w_op_hs    = op_valid && (r_state == ST_RUN);
    assign w_last     = w_op_hs && (r_cnt == LEN_W'(1));
    assign w_mfu_mode = ((r_state == ST_RUN) || (r_state == ST_DRAIN)) ? r_mode : MODE_NOOP;

    // DRAIN exits once stage 1 is empty: whatever sits in stage 2 is accumulated
    // on the same edge, so the result is complete when DONE is entered.
    always_comb begin
        w_state_nxt = r_state;
        cfg_ready   = 1'b0;
        op_ready    = 1'b0;
        res_valid   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                cfg_ready = 1'b1;
                if (cfg_valid) begin
                    if ((cfg_mode == MODE_NOOP) || (cfg_len == '0)) w_state_nxt = ST_DONE;
                    else                                           w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                op_ready = 1'b1;
                if (w_last) w_state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!r_vld_p1) w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                res_valid = 1'b1;
                if (res_ready) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= ST_IDLE;
            r_mode  <= MODE_NOOP;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_cfg_hs) begin
                r_mode <= cfg_mode;
                r_cnt  <= cfg_len;
            end else if (w_op_hs) begin
                r_cnt  <= r_cnt - LEN_W'(1);
            end
        end
    end

    // stage p0 -> p1: operand registers, zero on bubbles
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_a_p1   <= '0;
            r_b_p1   <= '0;
            r_vld_p1 <= 1'b0;
            r_vld_p2 <= 1'b0;
        end else begin
            r_a_p1   <= w_op_hs ? op_a : 8'h00;
            r_b_p1   <= w_op_hs ? op_b : 8'h00;
            r_vld_p1 <= w_op_hs;
            r_vld_p2 <= r_vld_p1;
        end
    end

    mfu u_mfu (
        .clk    (clk),
        .nrst   (nrst),
        .i_mode (w_mfu_mode),
        .i_a    (r_a_p1),
        .i_b    (r_b_p1),
        .o_p    (w_p_p2)
    );

    mfu_lane_reduce #(.ACC_W(ACC_W)) u_reduce (
        .i_mode (r_mode),
        .i_p    (w_p_p2),
        .o_sum  (w_sum_p2)
    );

    // stage p2 -> p3: accumulate
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_acc <= '0;
            r_ovf <= 1'b0;
        end else if (w_cfg_hs) begin
            r_acc <= '0;
            r_ovf <= 1'b0;
        end else if (r_vld_p2) begin
            r_acc <= r_acc + w_sum_p2;
            if (add_ovf(r_acc, w_sum_p2)) r_ovf <= 1'b1;
        end
    end

    assign res_data = r_acc;
    assign res_ovf  = r_ovf;
    assign busy     = (r_state != ST_IDLE);

endmodule

// File: tb/tb_mfu_dot_seq.sv
// Directed bench for mfu_dot_seq: a 32-bit and a 16-bit accumulator instance
// share one stimulus stream; expected results are hand-computed constants.
module tb_mfu_dot_seq;
    import mfu_pkg::*;

    logic        clk = 1'b0;
    logic        nrst;
    logic        cfg_valid, op_valid, res_ready;
    logic [1:0]  cfg_mode;
    logic [15:0] cfg_len;
    logic [7:0]  op_a, op_b;

    logic        a_cfg_ready, a_op_ready, a_res_valid, a_res_ovf, a_busy;
    logic [31:0] a_res_data;
    logic        b_cfg_ready, b_op_ready, b_res_valid, b_res_ovf, b_busy;
    logic [15:0] b_res_data;

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0] va [8];
    logic [7:0] vb [8];

    always #5 clk = ~clk;

    mfu_dot_seq #(.ACC_W(32), .LEN_W(16)) dut32 (
        .clk(clk), .nrst(nrst),
        .cfg_valid(cfg_valid), .cfg_ready(a_cfg_ready), .cfg_mode(cfg_mode), .cfg_len(cfg_len),
        .op_valid(op_valid), .op_ready(a_op_ready), .op_a(op_a), .op_b(op_b),
        .res_valid(a_res_valid), .res_ready(res_ready), .res_data(a_res_data),
        .res_ovf(a_res_ovf), .busy(a_busy)
    );

    mfu_dot_seq #(.ACC_W(16), .LEN_W(16)) dut16 (
        .clk(clk), .nrst(nrst),
        .cfg_valid(cfg_valid), .cfg_ready(b_cfg_ready), .cfg_mode(cfg_mode), .cfg_len(cfg_len),
        .op_valid(op_valid), .op_ready(b_op_ready), .op_a(op_a), .op_b(op_b),
        .res_valid(b_res_valid), .res_ready(res_ready), .res_data(b_res_data),
        .res_ovf(b_res_ovf), .busy(b_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input logic [1:0] mode, input int len);
        int t = 0;
        while (!a_cfg_ready && t < 100) begin
            step();
            t++;
        end
        if (t >= 100) chk("cfg_ready_timeout", 32'(a_cfg_ready), 32'd1);
        cfg_mode  = mode;
        cfg_len   = 16'(len);
        cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
    endtask

    task automatic send_beats(input int n, input bit toggle);
        int  i  = 0;
        int  t  = 0;
        bit  ph = 1'b0;
        bit  hs;
        while (i < n && t < 200) begin
            op_valid = toggle ? !ph : 1'b1;
            ph       = !ph;
            op_a     = va[i];
            op_b     = vb[i];
            hs       = op_valid && a_op_ready;
            step();
            if (hs) i++;
            t++;
        end
        op_valid = 1'b0;
        op_a     = 8'h00;
        op_b     = 8'h00;
        if (i < n) chk("beat_timeout", 32'(i), 32'(n));
    endtask

    task automatic finish_job(input string tag, input logic [31:0] exp32, input bit ovf32,
                              input logic [15:0] exp16, input bit ovf16, input int hold);
        int t = 0;
        while (!a_res_valid && t < 50) begin
            step();
            t++;
        end
        if (t >= 50) chk({tag, "_res_valid_timeout"}, 32'(a_res_valid), 32'd1);
        res_ready = 1'b0;
        for (int h = 0; h < hold; h++) begin
            chk({tag, "_hold_data"}, a_res_data, exp32);
            chk({tag, "_hold_cfg_ready"}, 32'(a_cfg_ready), 32'd0);
            chk({tag, "_hold_busy"}, 32'(a_busy), 32'd1);
            step();
        end
        res_ready = 1'b1;
        chk({tag, "_valid32"}, 32'(a_res_valid), 32'd1);
        chk({tag, "_data32"}, a_res_data, exp32);
        chk({tag, "_ovf32"}, 32'(a_res_ovf), 32'(ovf32));
        chk({tag, "_valid16"}, 32'(b_res_valid), 32'd1);
        chk({tag, "_data16"}, 32'(b_res_data), 32'(exp16));
        chk({tag, "_ovf16"}, 32'(b_res_ovf), 32'(ovf16));
        step();
        res_ready = 1'b0;
        chk({tag, "_after_valid"}, 32'(a_res_valid), 32'd0);
        chk({tag, "_after_busy"}, 32'(a_busy), 32'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_cfg_ready"}, 32'(a_cfg_ready), 32'd1);
        chk({tag, "_op_ready"}, 32'(a_op_ready), 32'd0);
        chk({tag, "_res_valid"}, 32'(a_res_valid), 32'd0);
        chk({tag, "_res_data"}, a_res_data, 32'd0);
        chk({tag, "_res_ovf"}, 32'(a_res_ovf), 32'd0);
        chk({tag, "_busy"}, 32'(a_busy), 32'd0);
        chk({tag, "_res_data16"}, 32'(b_res_data), 32'd0);
        chk({tag, "_busy16"}, 32'(b_busy), 32'd0);
    endtask

    initial begin
        int lat;
        nrst      = 1'b0;
        cfg_valid = 1'b0;
        cfg_mode  = 2'b00;
        cfg_len   = 16'd0;
        op_valid  = 1'b0;
        op_a      = 8'h00;
        op_b      = 8'h00;
        res_ready = 1'b0;
        #12;
        chk_reset_outputs("reset");
        step();
        nrst = 1'b1;
        step();

        // 8x8: 12 - 10 - 16256 = -16254
        va[0] = 8'h03; vb[0] = 8'h04;
        va[1] = 8'hFE; vb[1] = 8'h05;
        va[2] = 8'h7F; vb[2] = 8'h80;
        start_job(MODE_8X8, 3);
        send_beats(3, 1'b0);
        finish_job("j8x8", 32'hFFFFC082, 1'b0, 16'hC082, 1'b0, 0);

        // 4x4: (8 + 15) + (-7 + 6) = 22
        va[0] = 8'h23; vb[0] = 8'h45;
        va[1] = 8'hF2; vb[1] = 8'h73;
        start_job(MODE_4X4, 2);
        send_beats(2, 1'b0);
        finish_job("j4x4", 32'h00000016, 1'b0, 16'h0016, 1'b0, 0);

        // 2x2: 1 - 1 + 4 - 1 = 3, result three cycles after the beat
        va[0] = 8'h79; vb[0] = 8'h5B;
        start_job(MODE_2X2, 1);
        send_beats(1, 1'b0);
        lat = 1;
        while (!a_res_valid && lat < 20) begin
            step();
            lat++;
        end
        chk("j2x2_latency", 32'(lat), 32'd3);
        finish_job("j2x2", 32'd3, 1'b0, 16'd3, 1'b0, 0);

        // bubbles on op_valid plus back-pressure on the result
        for (int i = 0; i < 4; i++) begin
            va[i] = 8'h01;
            vb[i] = 8'h01;
        end
        start_job(MODE_8X8, 4);
        send_beats(4, 1'b1);
        finish_job("jtoggle", 32'd4, 1'b0, 16'd4, 1'b0, 5);

        // NOOP mode and zero length skip straight to a zero result
        start_job(MODE_NOOP, 5);
        chk("noop_op_ready", 32'(a_op_ready), 32'd0);
        chk("noop_res_valid", 32'(a_res_valid), 32'd1);
        finish_job("jnoop", 32'd0, 1'b0, 16'd0, 1'b0, 0);
        start_job(MODE_4X4, 0);
        chk("len0_op_ready", 32'(a_op_ready), 32'd0);
        chk("len0_res_valid", 32'(a_res_valid), 32'd1);
        finish_job("jlen0", 32'd0, 1'b0, 16'd0, 1'b0, 0);

        // 16384 + 16384: wraps to 0x8000 in the 16-bit accumulator only
        va[0] = 8'h80; vb[0] = 8'h80;
        va[1] = 8'h80; vb[1] = 8'h80;
        start_job(MODE_8X8, 2);
        send_beats(2, 1'b0);
        finish_job("jovf", 32'h00008000, 1'b0, 16'h8000, 1'b1, 0);

        // reset mid-job aborts it
        va[0] = 8'h11; vb[0] = 8'h22;
        start_job(MODE_8X8, 3);
        send_beats(1, 1'b0);
        chk("midrun_busy", 32'(a_busy), 32'd1);
        nrst = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        step();
        step();
        chk("midrst_res_valid_held", 32'(a_res_valid), 32'd0);
        nrst = 1'b1;
        step();

        // 256 - 15 = 241
        va[0] = 8'h10; vb[0] = 8'h10;
        va[1] = 8'h05; vb[1] = 8'hFD;
        start_job(MODE_8X8, 2);
        send_beats(2, 1'b0);
        finish_job("jpostrst", 32'd241, 1'b0, 16'd241, 1'b0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
